// File: rtl/lc3b_multicycle_core.sv
// Multicycle LC-3b subset core behind a single-entry 128-bit line buffer with a line-wide memory port.
// Optional: define LC3B_HALT_DETECT_EN to add a halt output that stops the core on BRnzp #-1 (16'h0FFF).
module lc3b_multicycle_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata,
  output logic [127:0] pmem_wdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address
`ifdef LC3B_HALT_DETECT_EN
  ,
  output logic         halt
`endif
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [2:0] {
    S_FETCH, S_FILL, S_DECODE, S_EXECUTE, S_MEM, S_WRITE, S_WB, S_HALTED
  } state_t;

  state_t state, next_state;

  logic [15:0]       pc, ir, src_a, src_b, src_st, result;
  logic [15:1]       mar;
  logic [7:0][15:0]  regs;
  logic [2:0]        cc;
  logic [11:0]       line_tag, fill_tag;
  logic [127:0]      line_data;
  logic              line_valid, fill_for_mem;

  logic [3:0]  opcode;
  logic        fetch_hit, mem_hit, br_taken, halt_now;
  logic [15:0] fetch_word, mem_word, sext_imm5, off9_x2, result_cc_src;

  assign opcode     = ir[15:12];
  assign fetch_hit  = line_valid && (line_tag == pc[15:4]);
  assign mem_hit    = line_valid && (line_tag == mar[15:4]);
  assign fetch_word = line_data[{pc[3:1], 4'b0000} +: 16];
  assign mem_word   = line_data[{mar[3:1], 4'b0000} +: 16];
  assign sext_imm5  = {{11{ir[4]}}, ir[4:0]};
  assign off9_x2    = {{6{ir[8]}}, ir[8:0], 1'b0};
  assign br_taken   = |(ir[11:9] & cc);
  assign result_cc_src = result;

`ifdef LC3B_HALT_DETECT_EN
  assign halt_now = (fetch_word == 16'h0FFF);
  assign halt     = (state == S_HALTED);
`else
  assign halt_now = 1'b0;
`endif

  // Requests come straight from the state, so reset drops them the instant rst_n falls.
  assign pmem_read    = (state == S_FILL);
  assign pmem_write   = (state == S_WRITE);
  assign pmem_address = (state == S_FILL)  ? {fill_tag, 4'h0} :
                        (state == S_WRITE) ? {line_tag, 4'h0} : 16'h0000;
  assign pmem_wdata   = (state == S_WRITE) ? line_data : 128'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:   if (!fetch_hit)    next_state = S_FILL;
                 else if (halt_now) next_state = S_HALTED;
                 else               next_state = S_DECODE;
      S_FILL:    if (pmem_resp) next_state = fill_for_mem ? S_MEM : S_FETCH;
      S_DECODE:  next_state = S_EXECUTE;
      S_EXECUTE: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT, OP_LEA: next_state = S_WB;
          OP_LDR, OP_STR:                 next_state = S_MEM;
          default:                        next_state = S_FETCH;
        endcase
      end
      S_MEM:     if (!mem_hit)            next_state = S_FILL;
                 else if (opcode == OP_STR) next_state = S_WRITE;
                 else                      next_state = S_WB;
      S_WRITE:   if (pmem_resp) next_state = S_FETCH;
      S_WB:      next_state = S_FETCH;
      S_HALTED:  next_state = S_HALTED;
      default:   next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      ir           <= 16'h0000;
      regs         <= '0;
      cc           <= 3'b010;
      line_valid   <= 1'b0;
      line_tag     <= 12'h000;
      line_data    <= 128'd0;
      fill_tag     <= 12'h000;
      fill_for_mem <= 1'b0;
      src_a        <= 16'h0000;
      src_b        <= 16'h0000;
      src_st       <= 16'h0000;
      result       <= 16'h0000;
      mar          <= 15'h0000;
    end else begin
      case (state)
        S_FETCH: begin
          if (!fetch_hit) begin
            fill_tag     <= pc[15:4];
            fill_for_mem <= 1'b0;
          end else if (!halt_now) begin
            ir <= fetch_word;
            pc <= pc + 16'd2;
          end
        end
        S_FILL: begin
          if (pmem_resp) begin
            line_data  <= pmem_rdata;
            line_tag   <= fill_tag;
            line_valid <= 1'b1;
          end
        end
        S_DECODE: begin
          src_a  <= regs[ir[8:6]];
          src_b  <= ir[5] ? sext_imm5 : regs[ir[2:0]];
          src_st <= regs[ir[11:9]];
        end
        S_EXECUTE: begin
          case (opcode)
            OP_ADD: result <= src_a + src_b;
            OP_AND: result <= src_a & src_b;
            OP_NOT: result <= ~src_a;
            OP_LEA: result <= pc + off9_x2;
            OP_BR:  if (br_taken) pc <= pc + off9_x2;
            OP_JMP: pc <= src_a;
            OP_LDR, OP_STR: mar <= src_a[15:1] + {{9{ir[5]}}, ir[5:0]};
            default: ;
          endcase
        end
        S_MEM: begin
          // A store always merges into a resident line, so misses fill first and come back here.
          if (!mem_hit) begin
            fill_tag     <= mar[15:4];
            fill_for_mem <= 1'b1;
          end else if (opcode == OP_STR) begin
            line_data[{mar[3:1], 4'b0000} +: 16] <= src_st;
          end else begin
            result <= mem_word;
          end
        end
        S_WB: begin
          regs[ir[11:9]] <= result;
          if (opcode != OP_LEA) begin
            cc <= result_cc_src[15]          ? 3'b100 :
                  (result_cc_src == 16'h0000) ? 3'b010 : 3'b001;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3b_multicycle_core.sv
// Directed self-checking bench for lc3b_multicycle_core with a line-wide memory model of adjustable latency.
module tb_lc3b_multicycle_core;

  logic         clk;
  logic         rst_n;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic [127:0] pmem_wdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
`ifdef LC3B_HALT_DETECT_EN
  logic         halt;
`endif

  logic [15:0]  mem [0:255];
  int           resp_delay;
  int           wait_cnt;
  int           read_count;
  int           write_count;
  logic [15:0]  last_waddr;
  logic [127:0] last_wdata;
  int           n_compared;
  int           n_mismatched;

  lc3b_multicycle_core #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .pmem_wdata   (pmem_wdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address)
`ifdef LC3B_HALT_DETECT_EN
    ,
    .halt         (halt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: answers a held request after resp_delay waiting cycles with a one-cycle resp pulse.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    wait_cnt   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || pmem_resp) begin
        pmem_resp = 1'b0;
        wait_cnt  = 0;
      end else if (pmem_read || pmem_write) begin
        if (wait_cnt < resp_delay) begin
          wait_cnt++;
        end else begin
          if (pmem_read) begin
            for (int k = 0; k < 8; k++)
              pmem_rdata[16*k +: 16] = mem[int'(pmem_address[8:4]) * 8 + k];
            read_count++;
          end else begin
            for (int k = 0; k < 8; k++)
              mem[int'(pmem_address[8:4]) * 8 + k] = pmem_wdata[16*k +: 16];
            write_count++;
            last_waddr = pmem_address;
            last_wdata = pmem_wdata;
          end
          pmem_resp = 1'b1;
          wait_cnt  = 0;
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic start_core();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    read_count  = 0;
    write_count = 0;
    last_waddr  = 16'h0000;
    last_wdata  = '0;
    rst_n = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_compared++; if (pmem_read !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_read: got %b expected 0", pmem_read); end
    n_compared++; if (pmem_write !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_write: got %b expected 0", pmem_write); end
    n_compared++; if (pmem_address !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL reset_addr: got %h expected 0000", pmem_address); end
    n_compared++; if (pmem_wdata !== 128'd0) begin n_mismatched++; $display("[TB] FAIL reset_wdata: got %h expected 0", pmem_wdata); end
    n_compared++; if (dut.pc !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL reset_pc: got %h expected 0000", dut.pc); end
    n_compared++; if (dut.cc !== 3'b010) begin n_mismatched++; $display("[TB] FAIL reset_cc: got %b expected 010", dut.cc); end
`ifdef LC3B_HALT_DETECT_EN
    n_compared++; if (halt !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_halt: got %b expected 0", halt); end
`endif
  endtask

  task automatic test_store();
    logic [127:0] exp_line;
    clear_mem();
    mem[0] = 16'h1225;
    mem[1] = 16'h1441;
    mem[2] = 16'h7408;
    mem[3] = 16'h0FFF;
    for (int k = 0; k < 8; k++) begin
      mem[8 + k] = 16'hA000 + 16'(k);
      exp_line[16*k +: 16] = (k == 0) ? 16'h000A : 16'hA000 + 16'(k);
    end
    resp_delay = 0;
    start_core();
    run_cycles(150);
    n_compared++; if (dut.regs[1] !== 16'h0005) begin n_mismatched++; $display("[TB] FAIL store_r1: got %h expected 0005", dut.regs[1]); end
    n_compared++; if (dut.regs[2] !== 16'h000A) begin n_mismatched++; $display("[TB] FAIL store_r2: got %h expected 000a", dut.regs[2]); end
    n_compared++; if (write_count !== 1) begin n_mismatched++; $display("[TB] FAIL store_wcount: got %0d expected 1", write_count); end
    n_compared++; if (last_waddr !== 16'h0010) begin n_mismatched++; $display("[TB] FAIL store_waddr: got %h expected 0010", last_waddr); end
    n_compared++; if (last_wdata !== exp_line) begin n_mismatched++; $display("[TB] FAIL store_wdata: got %h expected %h", last_wdata, exp_line); end
    n_compared++; if (read_count !== 3) begin n_mismatched++; $display("[TB] FAIL store_rcount: got %0d expected 3", read_count); end
  endtask

  task automatic load_branch_prog();
    clear_mem();
    mem[0] = 16'h1225;
    mem[1] = 16'h5660;
    mem[2] = 16'h0802;
    mem[3] = 16'h0402;
    mem[4] = 16'h1827;
    mem[5] = 16'h1A3F;
    mem[6] = 16'h1C23;
    mem[7] = 16'h0FFF;
  endtask

  task automatic test_branch();
    load_branch_prog();
    resp_delay = 0;
    start_core();
    run_cycles(150);
    n_compared++; if (dut.regs[3] !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL branch_r3: got %h expected 0000", dut.regs[3]); end
    n_compared++; if (dut.regs[4] !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL branch_brz_skip_r4: got %h expected 0000", dut.regs[4]); end
    n_compared++; if (dut.regs[5] !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL branch_brn_not_taken_r5: got %h expected 0000", dut.regs[5]); end
    n_compared++; if (dut.regs[6] !== 16'h0003) begin n_mismatched++; $display("[TB] FAIL branch_r6: got %h expected 0003", dut.regs[6]); end
    n_compared++; if (dut.cc !== 3'b001) begin n_mismatched++; $display("[TB] FAIL branch_cc: got %b expected 001", dut.cc); end
    n_compared++; if (read_count !== 1) begin n_mismatched++; $display("[TB] FAIL branch_one_read_per_line: got %0d expected 1", read_count); end
  endtask

  task automatic test_mixed();
    clear_mem();
    mem[0]  = 16'hE207;
    mem[1]  = 16'h6441;
    mem[2]  = 16'h96BF;
    mem[3]  = 16'hE808;
    mem[4]  = 16'hC100;
    mem[5]  = 16'h1A21;
    mem[6]  = 16'h0FFF;
    mem[7]  = 16'h0FFF;
    mem[9]  = 16'h8001;
    mem[12] = 16'h1CBF;
    mem[13] = 16'h0FFF;
    resp_delay = 0;
    start_core();
    run_cycles(200);
    n_compared++; if (dut.regs[1] !== 16'h0010) begin n_mismatched++; $display("[TB] FAIL mixed_lea_r1: got %h expected 0010", dut.regs[1]); end
    n_compared++; if (dut.regs[2] !== 16'h8001) begin n_mismatched++; $display("[TB] FAIL mixed_ldr_r2: got %h expected 8001", dut.regs[2]); end
    n_compared++; if (dut.regs[3] !== 16'h7FFE) begin n_mismatched++; $display("[TB] FAIL mixed_not_r3: got %h expected 7ffe", dut.regs[3]); end
    n_compared++; if (dut.regs[4] !== 16'h0018) begin n_mismatched++; $display("[TB] FAIL mixed_lea_r4: got %h expected 0018", dut.regs[4]); end
    n_compared++; if (dut.regs[5] !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL mixed_jmp_skip_r5: got %h expected 0000", dut.regs[5]); end
    n_compared++; if (dut.regs[6] !== 16'h8000) begin n_mismatched++; $display("[TB] FAIL mixed_add_r6: got %h expected 8000", dut.regs[6]); end
    n_compared++; if (dut.cc !== 3'b100) begin n_mismatched++; $display("[TB] FAIL mixed_cc: got %b expected 100", dut.cc); end
    n_compared++; if (read_count !== 4) begin n_mismatched++; $display("[TB] FAIL mixed_rcount: got %0d expected 4", read_count); end
    n_compared++; if (write_count !== 0) begin n_mismatched++; $display("[TB] FAIL mixed_wcount: got %0d expected 0", write_count); end
  endtask

  task automatic test_resp_delay();
    int guard;
    int held;
    logic [15:0] held_addr;
    load_branch_prog();
    resp_delay = 10;
    start_core();
    guard = 0;
    do begin
      @(negedge clk); #1;
      guard++;
    end while (!pmem_read && guard < 50);
    n_compared++; if (pmem_read !== 1'b1) begin n_mismatched++; $display("[TB] FAIL delay_read_seen: got %b expected 1", pmem_read); end
    held_addr = pmem_address;
    held = 0;
    while (!pmem_resp && held < 40) begin
      n_compared++;
      if (pmem_read !== 1'b1 || pmem_address !== held_addr) begin
        n_mismatched++;
        $display("[TB] FAIL delay_hold: got read=%b addr=%h expected read=1 addr=%h", pmem_read, pmem_address, held_addr);
      end
      held++;
      @(negedge clk); #1;
    end
    n_compared++; if (held !== 10) begin n_mismatched++; $display("[TB] FAIL delay_hold_cycles: got %0d expected 10", held); end
    n_compared++; if (held_addr !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL delay_addr: got %h expected 0000", held_addr); end
    @(negedge clk); #1;
    n_compared++; if (pmem_read !== 1'b0) begin n_mismatched++; $display("[TB] FAIL delay_deassert: got %b expected 0", pmem_read); end
    run_cycles(200);
    n_compared++; if (dut.regs[6] !== 16'h0003) begin n_mismatched++; $display("[TB] FAIL delay_r6: got %h expected 0003", dut.regs[6]); end
    n_compared++; if (read_count !== 1) begin n_mismatched++; $display("[TB] FAIL delay_rcount: got %0d expected 1", read_count); end
  endtask

  task automatic test_reset_mid();
    int guard;
    test_mixed_prog_load();
    resp_delay = 10;
    start_core();
    run_cycles(40);
    guard = 0;
    while (!pmem_read && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    n_compared++; if (pmem_read !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mid_read_seen: got %b expected 1", pmem_read); end
    n_compared++; if (dut.regs[1] !== 16'h0010) begin n_mismatched++; $display("[TB] FAIL mid_pre_r1: got %h expected 0010", dut.regs[1]); end
    #2;
    rst_n = 1'b0;
    #1;
    n_compared++; if (pmem_read !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_read: got %b expected 0", pmem_read); end
    n_compared++; if (pmem_write !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_write: got %b expected 0", pmem_write); end
    n_compared++; if (pmem_address !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL mid_addr: got %h expected 0000", pmem_address); end
    n_compared++; if (pmem_wdata !== 128'd0) begin n_mismatched++; $display("[TB] FAIL mid_wdata: got %h expected 0", pmem_wdata); end
    n_compared++; if (dut.pc !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL mid_pc: got %h expected 0000", dut.pc); end
    n_compared++; if (dut.cc !== 3'b010) begin n_mismatched++; $display("[TB] FAIL mid_cc: got %b expected 010", dut.cc); end
    n_compared++; if (dut.regs[1] !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL mid_r1: got %h expected 0000", dut.regs[1]); end
    resp_delay = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    guard = 0;
    do begin
      @(negedge clk); #1;
      guard++;
    end while (!pmem_read && !pmem_write && guard < 20);
    n_compared++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_first_req: got read=%b write=%b expected read=1 write=0", pmem_read, pmem_write); end
    n_compared++; if (pmem_address !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL mid_first_addr: got %h expected 0000", pmem_address); end
  endtask

  task automatic test_mixed_prog_load();
    clear_mem();
    mem[0]  = 16'hE207;
    mem[1]  = 16'h6441;
    mem[2]  = 16'h96BF;
    mem[3]  = 16'hE808;
    mem[4]  = 16'hC100;
    mem[5]  = 16'h1A21;
    mem[6]  = 16'h0FFF;
    mem[7]  = 16'h0FFF;
    mem[9]  = 16'h8001;
    mem[12] = 16'h1CBF;
    mem[13] = 16'h0FFF;
  endtask

`ifdef LC3B_HALT_DETECT_EN
  task automatic test_halt();
    int snap_reads;
    int snap_writes;
    load_branch_prog();
    resp_delay = 0;
    start_core();
    run_cycles(150);
    n_compared++; if (halt !== 1'b1) begin n_mismatched++; $display("[TB] FAIL halt_set: got %b expected 1", halt); end
    snap_reads  = read_count;
    snap_writes = write_count;
    run_cycles(50);
    n_compared++; if (read_count !== snap_reads || write_count !== snap_writes) begin n_mismatched++; $display("[TB] FAIL halt_quiet: got reads=%0d writes=%0d expected reads=%0d writes=%0d", read_count, write_count, snap_reads, snap_writes); end
    n_compared++; if (dut.regs[6] !== 16'h0003) begin n_mismatched++; $display("[TB] FAIL halt_r6: got %h expected 0003", dut.regs[6]); end
  endtask
`endif

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    resp_delay   = 0;
    read_count   = 0;
    write_count  = 0;
    last_waddr   = 16'h0000;
    last_wdata   = '0;
    rst_n        = 1'b0;
    clear_mem();
    test_reset();
    test_store();
    test_branch();
    test_mixed();
    test_resp_delay();
    test_reset_mid();
`ifdef LC3B_HALT_DETECT_EN
    test_halt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
